iram_download_loader: RTL and testbench

- System-bus peripheral that fills the user instruction RAM while the SoC runs from boot ROM in download mode.
- Boot firmware writes program bytes one at a time. The block assembles them little-endian into 32-bit words, issues one-cycle word writes to the instruction RAM write port, and keeps an 8-bit byte checksum.
- Downstream consumer: the instruction-fetch mux, which switches to user code once firmware confirms the load is DONE.

---
 rtl/iram_download_loader.sv | 145 ++++++++++++++
 tb/tb_iram_download_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iram_download_loader.sv
// Download-mode loader: packs bus byte writes little-endian into 32-bit words and
// streams them into the instruction RAM write port, tracking word count and a byte checksum.
module iram_download_loader #(
   parameter int IRAM_AW = 12,
   parameter int REG_AW  = 2
) (
   input  logic               hb_clk,
   input  logic               rst_sync,
   input  logic               bus_wen,
   input  logic               bus_ren,
   input  logic [REG_AW-1:0]  bus_waddr,
   input  logic [REG_AW-1:0]  bus_raddr,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        rdata,
   input  logic               download_mode,
   output logic               iram_we,
   output logic [IRAM_AW-1:0] iram_waddr,
   output logic [31:0]        iram_wdata,
   output logic               load_done
);

   localparam logic [REG_AW-1:0] REG_CTRL = REG_AW'(0);
   localparam logic [REG_AW-1:0] REG_BASE = REG_AW'(1);
   localparam logic [REG_AW-1:0] REG_DATA = REG_AW'(2);
   localparam logic [REG_AW-1:0] REG_LEN  = REG_AW'(3);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t             state;
   logic [1:0]         byte_cnt;
   logic [IRAM_AW-1:0] word_addr;
   logic [IRAM_AW:0]   word_cnt;
   logic [IRAM_AW:0]   len;
   logic [7:0]         checksum;
   logic [23:0]        shift_reg;
   logic               err_data;
   logic               err_wrap;
   logic               err_mode;

   logic               wr_ctrl;
   logic               wr_data;
   logic               start;
   logic               abort;
   logic [IRAM_AW:0]   word_cnt_inc;
   logic               unused_wdata;

   assign wr_ctrl      = bus_wen && (bus_waddr == REG_CTRL);
   assign wr_data      = bus_wen && (bus_waddr == REG_DATA);
   assign abort        = wr_ctrl && bus_wdata[1];
   assign start        = wr_ctrl && bus_wdata[0] && !bus_wdata[1];
   assign word_cnt_inc = word_cnt + 1'b1;
   assign unused_wdata = ^bus_wdata;

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         state      <= S_IDLE;
         byte_cnt   <= '0;
         word_addr  <= '0;
         word_cnt   <= '0;
         len        <= '0;
         checksum   <= '0;
         shift_reg  <= '0;
         err_data   <= 1'b0;
         err_wrap   <= 1'b0;
         err_mode   <= 1'b0;
         rdata      <= '0;
         iram_we    <= 1'b0;
         iram_waddr <= '0;
         iram_wdata <= '0;
         load_done  <= 1'b0;
      end else begin
         iram_we <= 1'b0;

         if (bus_ren) begin
            case (bus_raddr)
               REG_CTRL: rdata <= {26'd0, load_done, err_mode, err_wrap, err_data,
                                   state == S_LOAD, download_mode};
               REG_BASE: rdata <= 32'(word_addr);
               REG_DATA: rdata <= 32'(checksum);
               default:  rdata <= 32'(word_cnt);
            endcase
         end

         case (state)
            S_LOAD: begin
               // Losing the strap or an abort drops any partially assembled word.
               if (!download_mode || abort) begin
                  state     <= S_IDLE;
                  load_done <= 1'b0;
                  byte_cnt  <= '0;
                  shift_reg <= '0;
                  if (!download_mode) err_mode <= 1'b1;
               end else if (wr_data) begin
                  checksum <= checksum + bus_wdata[7:0];
                  case (byte_cnt)
                     2'd0: shift_reg[7:0]   <= bus_wdata[7:0];
                     2'd1: shift_reg[15:8]  <= bus_wdata[7:0];
                     2'd2: shift_reg[23:16] <= bus_wdata[7:0];
                     default: ;
                  endcase
                  byte_cnt <= byte_cnt + 1'b1;
                  // Word complete: the RAM strobe and counter updates share one edge.
                  if (byte_cnt == 2'd3) begin
                     iram_we    <= 1'b1;
                     iram_wdata <= {bus_wdata[7:0], shift_reg};
                     iram_waddr <= word_addr;
                     word_addr  <= word_addr + 1'b1;
                     word_cnt   <= word_cnt_inc;
                     if (&word_addr) err_wrap <= 1'b1;
                     if (word_cnt_inc == len) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (bus_wen && (bus_waddr == REG_BASE)) word_addr <= bus_wdata[IRAM_AW-1:0];
               if (bus_wen && (bus_waddr == REG_LEN))  len       <= bus_wdata[IRAM_AW:0];
               if (wr_data) err_data <= 1'b1;
               if (abort && (state == S_DONE)) begin
                  state     <= S_IDLE;
                  load_done <= 1'b0;
               end else if (start && download_mode) begin
                  byte_cnt  <= '0;
                  word_cnt  <= '0;
                  checksum  <= '0;
                  shift_reg <= '0;
                  err_data  <= 1'b0;
                  err_wrap  <= 1'b0;
                  err_mode  <= 1'b0;
                  if (len == '0) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                  end else begin
                     state     <= S_LOAD;
                     load_done <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iram_download_loader.sv
// Scoreboarded bench for iram_download_loader: directed scenarios followed by random
// bus traffic, checked against a byte-queue reference model.
module tb_iram_download_loader;

   logic        hb_clk = 1'b0;
   logic        rst_sync = 1'b1;
   logic        bus_wen = 1'b0;
   logic        bus_ren = 1'b0;
   logic [1:0]  bus_waddr = '0;
   logic [1:0]  bus_raddr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] rdata;
   logic        download_mode = 1'b1;
   logic        iram_we;
   logic [11:0] iram_waddr;
   logic [31:0] iram_wdata;
   logic        load_done;

   iram_download_loader #(.IRAM_AW(12), .REG_AW(2)) dut (
      .hb_clk(hb_clk), .rst_sync(rst_sync), .bus_wen(bus_wen), .bus_ren(bus_ren),
      .bus_waddr(bus_waddr), .bus_raddr(bus_raddr), .bus_wdata(bus_wdata), .rdata(rdata),
      .download_mode(download_mode), .iram_we(iram_we), .iram_waddr(iram_waddr),
      .iram_wdata(iram_wdata), .load_done(load_done)
   );

   always #5 hb_clk = ~hb_clk;

   int errors = 0;
   int checks = 0;

   typedef struct packed {logic [11:0] a; logic [31:0] d;} wr_t;
   wr_t         exp_wr_q[$];
   logic [31:0] exp_rd_q[$];

   // reference model: 0 idle, 1 loading, 2 done
   int          m_st;
   logic [7:0]  m_bytes[$];
   int unsigned m_addr, m_cnt, m_len, m_sum;
   bit          m_ed, m_ew, m_em;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_bytes.delete(); m_addr = 0; m_cnt = 0; m_len = 0; m_sum = 0;
      m_ed = 0; m_ew = 0; m_em = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] ra);
      case (ra)
         2'd0: return {26'd0, m_st == 2, m_em, m_ew, m_ed, m_st == 1, download_mode};
         2'd1: return m_addr;
         2'd2: return m_sum;
         default: return m_cnt;
      endcase
   endfunction

   task automatic m_step(input bit wen, input logic [1:0] wa, input logic [31:0] wd);
      logic [31:0] w;
      if (m_st == 1) begin
         if (!download_mode) begin
            m_st = 0; m_bytes.delete(); m_em = 1;
         end else if (wen && wa == 2'd0 && wd[1]) begin
            m_st = 0; m_bytes.delete();
         end else if (wen && wa == 2'd2) begin
            m_bytes.push_back(wd[7:0]);
            m_sum = (m_sum + wd[7:0]) % 256;
            if (m_bytes.size() == 4) begin
               w = m_bytes[0] + 256 * m_bytes[1] + 65536 * m_bytes[2] + 16777216 * m_bytes[3];
               exp_wr_q.push_back('{a: 12'(m_addr), d: w});
               if (m_addr == 4095) m_ew = 1;
               m_addr = (m_addr + 1) % 4096;
               m_cnt++;
               m_bytes.delete();
               if (m_cnt == m_len) m_st = 2;
            end
         end
      end else if (wen) begin
         case (wa)
            2'd1: m_addr = wd % 4096;
            2'd2: m_ed = 1;
            2'd3: m_len = wd % 8192;
            default: begin
               if (wd[1]) begin
                  if (m_st == 2) m_st = 0;
               end else if (wd[0] && download_mode) begin
                  m_cnt = 0; m_sum = 0; m_ed = 0; m_ew = 0; m_em = 0; m_bytes.delete();
                  m_st = (m_len == 0) ? 2 : 1;
               end
            end
         endcase
      end
   endtask

   // One bus cycle; expectations are taken from the model before it advances.
   task automatic cycle(input bit wen, input logic [1:0] wa, input logic [31:0] wd,
                        input bit ren, input logic [1:0] ra, input bit use_c,
                        input logic [31:0] c);
      @(posedge hb_clk); #1;
      bus_wen = wen; bus_waddr = wa; bus_wdata = wd; bus_ren = ren; bus_raddr = ra;
      if (ren) exp_rd_q.push_back(use_c ? c : m_read(ra));
      m_step(wen, wa, wd);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cycle(1'b1, a, d, 1'b0, 2'd0, 1'b0, 32'd0);
   endtask
   task automatic rd(input logic [1:0] a);
      cycle(1'b0, 2'd0, 32'd0, 1'b1, a, 1'b0, 32'd0);
   endtask
   task automatic rdc(input logic [1:0] a, input logic [31:0] c);
      cycle(1'b0, 2'd0, 32'd0, 1'b1, a, 1'b1, c);
   endtask
   task automatic idle();
      cycle(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
   endtask
   task automatic set_mode(input logic v);
      @(posedge hb_clk); #1;
      download_mode = v; bus_wen = 1'b0; bus_ren = 1'b0;
      m_step(1'b0, 2'd0, 32'd0);
   endtask

   bit rd_pend = 0;
   wr_t e;
   always @(negedge hb_clk) begin
      if (rd_pend) begin
         if (exp_rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
         else check("rdata", rdata, exp_rd_q.pop_front());
      end
      rd_pend = bus_ren && !rst_sync;
      if (iram_we) begin
         if (exp_wr_q.size() == 0) check("iram_we_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_wr_q.pop_front();
            check("iram_waddr", 32'(iram_waddr), 32'(e.a));
            check("iram_wdata", iram_wdata, e.d);
         end
      end
   end

   logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
   int r;

   initial begin
      m_reset();
      #12 rst_sync = 1'b0;
      check("reset_iram_we", 32'(iram_we), 32'd0);
      check("reset_load_done", 32'(load_done), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      rdc(2'd0, 32'h1);

      // two-word program at 0x010
      wr(2'd1, 32'h010); wr(2'd3, 32'd2); wr(2'd0, 32'd1);
      for (int i = 0; i < 8; i++) wr(2'd2, 32'(prog[i]));
      idle();
      check("done_after_load", 32'(load_done), 32'd1);
      rdc(2'd2, 32'h82); rdc(2'd3, 32'd2); rdc(2'd0, 32'h21);

      // abort mid-word, then a stray data write
      wr(2'd3, 32'd1); wr(2'd0, 32'd1); wr(2'd2, 32'hAB); wr(2'd2, 32'hCD); wr(2'd0, 32'd2);
      rdc(2'd0, 32'h01);
      wr(2'd2, 32'h55); rdc(2'd0, 32'h05);

      // address wrap
      wr(2'd1, 32'hFFF); wr(2'd3, 32'd2); wr(2'd0, 32'd1);
      for (int i = 0; i < 8; i++) wr(2'd2, $urandom);
      rdc(2'd0, 32'h29); rdc(2'd1, 32'h1);

      // strap dropped mid-load
      wr(2'd0, 32'd1); wr(2'd2, 32'hAA); set_mode(1'b0);
      rdc(2'd0, 32'h10);
      wr(2'd0, 32'd1); rdc(2'd0, 32'h10); rdc(2'd3, 32'd0);
      set_mode(1'b1);

      // zero-length load
      wr(2'd3, 32'd0); wr(2'd0, 32'd1); idle();
      check("len0_done", 32'(load_done), 32'd1);
      rdc(2'd0, 32'h21);

      // asynchronous reset while the word strobe is high
      wr(2'd3, 32'd1); wr(2'd0, 32'd1);
      for (int i = 0; i < 4; i++) wr(2'd2, 32'h11 * (i + 1));
      @(posedge hb_clk); #1;
      bus_wen = 1'b0; bus_ren = 1'b0;
      check("strobe_before_reset", 32'(iram_we), 32'd1);
      #1 rst_sync = 1'b1;
      #1;
      check("async_iram_we", 32'(iram_we), 32'd0);
      check("async_load_done", 32'(load_done), 32'd0);
      check("async_iram_waddr", 32'(iram_waddr), 32'd0);
      check("async_iram_wdata", iram_wdata, 32'd0);
      check("async_rdata", rdata, 32'd0);
      exp_wr_q.delete(); exp_rd_q.delete(); rd_pend = 0; m_reset();
      #1 rst_sync = 1'b0;
      rdc(2'd0, 32'h1);

      // random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if (!download_mode) begin
            if ($urandom_range(0, 3) == 0) set_mode(1'b1); else idle();
            continue;
         end
         r = $urandom_range(0, 99);
         if (r < 55)      wr(2'd2, $urandom);
         else if (r < 63) rd(2'($urandom_range(0, 3)));
         else if (r < 70) wr(2'd0, 32'd1);
         else if (r < 72) wr(2'd0, 32'($urandom_range(2, 3)));
         else if (r < 76) wr(2'd1, $urandom_range(0, 1) ? 32'($urandom_range(4092, 4095)) : $urandom);
         else if (r < 80) wr(2'd3, 32'($urandom_range(0, 4)));
         else if (r < 82) set_mode(1'b0);
         else             idle();
      end
      rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
      repeat (4) idle();
      check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
